cp0_irq_ctrl: RTL
=================

# cp0_irq_ctrl

Parametrised successor to the single-cause coprocessor 0 used by the multicycle MIPS data path. It holds Status, Cause, EPC, Count and Compare. It latches up to `NUM_IRQ` external interrupt lines plus an internal timer interrupt, applies per-line masking, and arbitrates syscall exceptions against interrupts. It tells the controller when to redirect the PC to the exception vector. It sits beside the register file: `mfc0`/`mtc0` traffic on one side, the controller's FSM and PC mux on the other.

## Interface
Parameters:
- `WIDTH`, 32, data/address width of every CP0 register.
- `NUM_IRQ`, 4, number of external interrupt lines, legal range 1..7; they map to Cause/Status bits [8+NUM_IRQ-1:8].
- `EXC_VECTOR`, 32'h0000_0004, exception handler address.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_i`  in  NUM_IRQ  level interrupt lines, synchronous to `clk`.
- `c0_rd_addr`  in  5  `mfc0` register select.
- `c0_r_data`  out  WIDTH  read data for `c0_rd_addr`.
- `c0_wr_addr`  in  5  `mtc0` register select.
- `c0_w_data`  in  WIDTH  `mtc0` write data.
- `c0_reg_we`  in  1  `mtc0` write strobe.
- `inst_boundary`  in  1  high in the controller's fetch state, when an interrupt may be taken.
- `pc_i`  in  WIDTH  restart address for the instruction about to execute.
- `syscall_i`  in  1  syscall exception request, one cycle.
- `eret_i`  in  1  exception return, one cycle.
- `exc_take`  out  1  redirect PC to `exc_vector` this cycle.
- `exc_vector`  out  WIDTH  constant `EXC_VECTOR`.
- `epc_o`  out  WIDTH  current EPC, used as the eret target.

## Operation
Register map. Unimplemented addresses read 0 and ignore writes.
- 9 Count: increments every cycle, wraps, and is writable.
- 11 Compare: writable. Any write clears the timer pending bit TI.
- 12 Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM, bit15 IM_T (timer mask). All other bits read 0.
- 13 Cause: bits[6:2] ExcCode (read-only), bits[8+NUM_IRQ-1:8] IP, bit15 TI.
  - Writing 1 to an IP or TI bit clears it; writing 0 leaves it unchanged.
- 14 EPC: writable.

Interrupt sources:
- `irq_i` is registered into `irq_q`. A rising edge (`irq_i & ~irq_q`) sets the matching IP bit.
- Timer: when Count increments to a value equal to Compare, TI sets.

Interrupt take: `int_pend = |(IP & IM) | (TI & IM_T)`. The interrupt is taken when `inst_boundary & IE & ~EXL & int_pend`.
- `exc_take` goes high combinationally.
- At the edge: EPC<=`pc_i`, EXL<=1, ExcCode<=0.

Syscall: `syscall_i` forces `exc_take` high regardless of IE, and ExcCode<=8.
- If EXL=0: EPC<=`pc_i`, EXL<=1.
- If EXL=1: EPC and EXL are unchanged.

Eret: `eret_i` sets EXL<=0; EPC is unchanged.

Priority when events coincide in the same cycle:
1. `eret_i` over an interrupt: the interrupt is deferred and `exc_take` is low.
2. `syscall_i` over an interrupt: ExcCode=8, and the IP bits stay pending.
3. Hardware update over `mtc0` for the fields it touches (EPC, EXL, ExcCode). The `mtc0` still applies to all other fields.
4. An IP/TI set event over a same-cycle software clear: the bit stays 1.

Reset: Status=0, Cause=0, EPC=0, Count=0, Compare=all-ones, `irq_q`=0.

## Timing
- `c0_r_data`, `exc_take` and `epc_o` are combinational from registered state and current inputs. `mtc0` results become visible the cycle after the write.
- Interrupt latency from an `irq_i` rise sampled at edge N:
  - IP is visible after edge N.
  - `exc_take` can assert in the first cycle after edge N in which `inst_boundary` is high.
- Syscall: `exc_take` asserts in the same cycle as `syscall_i`.
- Timer: TI is visible the cycle after Count reaches Compare.
- `reset` high overrides every other input in that cycle, including a pending take or write.
- `exc_vector` is constant in every cycle, including during reset.
- Outputs after reset: `exc_take`=0, `epc_o`=0, `c0_r_data`=0 for every address except 11 (Compare), which reads all-ones.

## Test plan
- NUM_IRQ=4. Set Status=32'h0000_0201 (IE=1, IM[9]). Pulse `irq_i`=4'b0010. Hold `inst_boundary`=1 with `pc_i`=32'h40.
  - Required: `exc_take`=1 exactly one cycle after the edge sample; EPC=32'h40, EXL=1, Cause=32'h0000_0200.
- Same setup with Status=32'h0000_0101 (line 1 masked).
  - Required: IP[9] sets, `exc_take` stays 0.
  - Then write Cause=32'h200: IP clears.
- `syscall_i` with `pc_i`=32'h1C while EXL=0: `exc_take`=1, EPC=32'h1C, ExcCode=8.
  - Repeat with EXL=1: EPC stays 32'h1C.
- Set Compare=10 with Count=0. Set Status=32'h0000_8001.
  - Required: TI sets when Count reaches 10, interrupt is taken at the next boundary.
  - Writing Compare clears TI.
- Same-cycle collisions:
  - `eret_i` plus an enabled pending interrupt: `exc_take`=0, EXL=0; the take occurs at the next boundary.
  - `mtc0` to EPC=32'h99 in the same cycle as a take with `pc_i`=32'h50: EPC=32'h50.
- Assert `reset` in the cycle of a take: all registers at reset values and `exc_take` low.
  - Compare reads 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor 0 for the multicycle MIPS core: Status/Cause/EPC/Count/Compare,
// masked external and timer interrupts, syscall and eret sequencing.
module cp0_irq_ctrl #(
    parameter int               WIDTH      = 32,
    parameter int               NUM_IRQ    = 4,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [4:0]         c0_rd_addr,
    output logic [WIDTH-1:0]   c0_r_data,
    input  logic [4:0]         c0_wr_addr,
    input  logic [WIDTH-1:0]   c0_w_data,
    input  logic               c0_reg_we,
    input  logic               inst_boundary,
    input  logic [WIDTH-1:0]   pc_i,
    input  logic               syscall_i,
    input  logic               eret_i,
    output logic               exc_take,
    output logic [WIDTH-1:0]   exc_vector,
    output logic [WIDTH-1:0]   epc_o
);

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] EXC_INT   = 5'd0;
    localparam logic [4:0] EXC_SYS   = 5'd8;

    logic               ie, exl, im_t, ti;
    logic [NUM_IRQ-1:0] im, ip, irq_q;
    logic [4:0]         exc_code;
    logic [WIDTH-1:0]   epc, count, compare;

    logic               we_count, we_compare, we_status, we_cause, we_epc;
    logic               int_pend, int_take, epc_capture;
    logic [WIDTH-1:0]   count_inc;
    logic [NUM_IRQ-1:0] ip_set, ip_clr;
    logic               ti_set, ti_clr;
    logic               unused_wdata;

    assign we_count   = c0_reg_we && (c0_wr_addr == A_COUNT);
    assign we_compare = c0_reg_we && (c0_wr_addr == A_COMPARE);
    assign we_status  = c0_reg_we && (c0_wr_addr == A_STATUS);
    assign we_cause   = c0_reg_we && (c0_wr_addr == A_CAUSE);
    assign we_epc     = c0_reg_we && (c0_wr_addr == A_EPC);

    // eret and syscall both pre-empt an interrupt in the same cycle
    assign int_pend    = (|(ip & im)) | (ti & im_t);
    assign int_take    = inst_boundary & ie & ~exl & int_pend & ~eret_i & ~syscall_i;
    assign epc_capture = int_take | (syscall_i & ~exl);
    assign exc_take    = ~reset & (syscall_i | int_take);

    assign count_inc = count + WIDTH'(1);
    assign ip_set    = irq_i & ~irq_q;
    assign ip_clr    = we_cause ? c0_w_data[8 +: NUM_IRQ] : '0;
    assign ti_set    = ~we_count & (count_inc == compare);
    assign ti_clr    = we_compare | (we_cause & c0_w_data[15]);

    assign exc_vector   = EXC_VECTOR;
    assign epc_o        = epc;
    assign unused_wdata = ^c0_w_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im_t     <= 1'b0;
            ti       <= 1'b0;
            im       <= '0;
            ip       <= '0;
            irq_q    <= '0;
            exc_code <= '0;
            epc      <= '0;
            count    <= '0;
            compare  <= '1;
        end else begin
            irq_q <= irq_i;
            count <= we_count ? c0_w_data : count_inc;
            if (we_compare) compare <= c0_w_data;
            if (we_status) begin
                ie   <= c0_w_data[0];
                im   <= c0_w_data[8 +: NUM_IRQ];
                im_t <= c0_w_data[15];
            end
            // hardware exception entry/exit owns EXL, EPC and ExcCode over mtc0
            if (epc_capture)    exl <= 1'b1;
            else if (eret_i)    exl <= 1'b0;
            else if (we_status) exl <= c0_w_data[1];
            if (epc_capture)    epc <= pc_i;
            else if (we_epc)    epc <= c0_w_data;
            if (syscall_i)      exc_code <= EXC_SYS;
            else if (int_take)  exc_code <= EXC_INT;
            // set events win over a same-cycle write-1-to-clear
            ip <= (ip & ~ip_clr) | ip_set;
            ti <= (ti & ~ti_clr) | ti_set;
        end
    end

    always_comb begin
        c0_r_data = '0;
        case (c0_rd_addr)
            A_COUNT:   c0_r_data = count;
            A_COMPARE: c0_r_data = compare;
            A_STATUS: begin
                c0_r_data[0]            = ie;
                c0_r_data[1]            = exl;
                c0_r_data[8 +: NUM_IRQ] = im;
                c0_r_data[15]           = im_t;
            end
            A_CAUSE: begin
                c0_r_data[6:2]          = exc_code;
                c0_r_data[8 +: NUM_IRQ] = ip;
                c0_r_data[15]           = ti;
            end
            A_EPC:     c0_r_data = epc;
            default:   c0_r_data = '0;
        endcase
    end

endmodule
